col_end_fifo: RTL and testbench

- Column-end FIFO that buffers 28-bit hit words from first-level column arbitration.
- Answers the second-level proc arbiter's pop handshake. Its `route_data`/`empty` outputs feed one arbiter input pair; its `shake_hands` input is one bit of the arbiter's `shake_hands_merge`.
- Show-ahead (first-word-fall-through): the head word is always presented. A pop strobe retires it at the next clk_40MHz edge.
- Two instances serve the two arbiter inputs.

---
 rtl/col_end_fifo.sv | 93 +++++++++
 tb/tb_col_end_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/col_end_fifo.sv
// Column-end show-ahead FIFO for 28-bit hit words; pops come from the second-level
// proc arbiter's shake_hands strobe, pushes from the first-level column arbiter.
`timescale 1ns/1ps

module col_end_fifo #(
    parameter int DATA_W   = 28,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = 12
) (
    input  logic              clk_40MHz,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              shake_hands,
    output logic [DATA_W-1:0] route_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic [7:0]        ovf_cnt
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W + 1)'(AFULL_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        ovf_cnt_q, ovf_cnt_d;
    logic              pop_vld, push_acc, push_drop;

    always_comb begin
        pop_vld   = shake_hands && (count_q != '0) && !flush;
        push_acc  = wr_en && !flush && ((count_q != DEPTH_C) || pop_vld);
        push_drop = wr_en && !flush && (count_q == DEPTH_C) && !pop_vld;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_cnt_d = ovf_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_vld)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_acc, pop_vld})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Dropped pushes saturate rather than wrap; flush never clears this.
        if (push_drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of block ordering.
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // NOTE: the storage array has no reset; count_q gates route_data, so stale
    // contents are never visible and the array can map onto plain flops/RAM.
    always_ff @(posedge clk_40MHz) begin
        if (push_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    // Outputs decode registered state only, so shake_hands has no path to them.
    assign route_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q >= AFULL_C);
    assign count       = count_q;
    assign ovf_cnt     = ovf_cnt_q;

endmodule

// File: tb/tb_col_end_fifo.sv
// Self-checking bench for col_end_fifo: vector table for the basic flow plus a
// queue scoreboard/model for fill, overflow, wrap, flush and async reset.
`timescale 1ns/1ps

module tb_col_end_fifo;

    logic        clk_40MHz = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wr_en;
    logic [27:0] wr_data;
    logic        shake_hands;
    logic [27:0] route_data;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic [4:0]  count;
    logic [7:0]  ovf_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_popped = 0;

    logic [27:0] mq[$];
    int          m_ovf = 0;

    typedef struct {
        logic        fl;
        logic        we;
        logic [27:0] wd;
        logic        sh;
        logic [4:0]  e_count;
        logic        e_empty;
        logic [27:0] e_head;
    } vec_t;

    vec_t tbl[11];

    col_end_fifo dut (
        .clk_40MHz   (clk_40MHz),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .shake_hands (shake_hands),
        .route_data  (route_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .ovf_cnt     (ovf_cnt)
    );

    always #12.5 clk_40MHz = ~clk_40MHz;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [27:0] head;
        head = (mq.size() != 0) ? mq[0] : 28'h0;
        check("count",       32'(count),       32'(mq.size()));
        check("empty",       32'(empty),       32'(mq.size() == 0));
        check("full",        32'(full),        32'(mq.size() == 16));
        check("almost_full", 32'(almost_full), 32'(mq.size() >= 12));
        check("route_data",  32'(route_data),  32'(head));
        check("ovf_cnt",     32'(ovf_cnt),     32'(m_ovf));
    endtask

    // Drive one cycle of stimulus, advance the model/scoreboard, then sample
    // 1 ns after the active edge.
    task automatic cycle(input logic fl, input logic we, input logic [27:0] wd, input logic sh);
        logic [27:0] exp_head;
        flush       = fl;
        wr_en       = we;
        wr_data     = wd;
        shake_hands = sh;
        if (fl) begin
            mq.delete();
        end else begin
            if (sh && mq.size() != 0) begin
                exp_head = mq.pop_front();
                check("pop_head", 32'(route_data), 32'(exp_head));
                n_popped++;
            end
            if (we) begin
                if (mq.size() < 16) mq.push_back(wd);
                else if (m_ovf < 255) m_ovf++;
            end
        end
        @(posedge clk_40MHz);
        #1;
        flush       = 1'b0;
        wr_en       = 1'b0;
        shake_hands = 1'b0;
        check_state();
    endtask

    initial begin
        int popped_before;

        rst_n       = 1'b0;
        flush       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        shake_hands = 1'b0;

        //         fl    we    wd            sh    cnt  emp   head
        tbl[0]  = '{1'b0, 1'b0, 28'h0,       1'b1, 5'd0, 1'b1, 28'h0};
        tbl[1]  = '{1'b0, 1'b0, 28'h0,       1'b1, 5'd0, 1'b1, 28'h0};
        tbl[2]  = '{1'b0, 1'b0, 28'h0,       1'b1, 5'd0, 1'b1, 28'h0};
        tbl[3]  = '{1'b0, 1'b1, 28'hA000001, 1'b0, 5'd1, 1'b0, 28'hA000001};
        tbl[4]  = '{1'b0, 1'b1, 28'hA000002, 1'b0, 5'd2, 1'b0, 28'hA000001};
        tbl[5]  = '{1'b0, 1'b1, 28'hA000003, 1'b0, 5'd3, 1'b0, 28'hA000001};
        tbl[6]  = '{1'b0, 1'b0, 28'h0,       1'b1, 5'd2, 1'b0, 28'hA000002};
        tbl[7]  = '{1'b0, 1'b0, 28'h0,       1'b1, 5'd1, 1'b0, 28'hA000003};
        tbl[8]  = '{1'b0, 1'b0, 28'h0,       1'b1, 5'd0, 1'b1, 28'h0};
        tbl[9]  = '{1'b0, 1'b1, 28'h0B00000, 1'b1, 5'd1, 1'b0, 28'h0B00000};
        tbl[10] = '{1'b0, 1'b0, 28'h0,       1'b1, 5'd0, 1'b1, 28'h0};

        repeat (3) @(posedge clk_40MHz);
        #1;
        check_state();
        rst_n = 1'b1;
        @(posedge clk_40MHz);
        #1;
        check_state();

        // Idle pops, three pushes/pops, push+pop on empty.
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].fl, tbl[i].we, tbl[i].wd, tbl[i].sh);
            check($sformatf("tbl%0d_count", i), 32'(count),      32'(tbl[i].e_count));
            check($sformatf("tbl%0d_empty", i), 32'(empty),      32'(tbl[i].e_empty));
            check($sformatf("tbl%0d_head", i),  32'(route_data), 32'(tbl[i].e_head));
        end

        // Fill to 16, two dropped pushes, then push+pop while full.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 28'hC000000 + 28'(i), 1'b0);
            if (i == 10) check("afull_at_11", 32'(almost_full), 32'd0);
            if (i == 11) check("afull_at_12", 32'(almost_full), 32'd1);
        end
        check("full_at_16", 32'(full), 32'd1);
        cycle(1'b0, 1'b1, 28'hEEEEEE1, 1'b0);
        cycle(1'b0, 1'b1, 28'hEEEEEE2, 1'b0);
        check("ovf_after_drops", 32'(ovf_cnt),    32'd2);
        check("head_after_drops", 32'(route_data), 32'hC000000);
        cycle(1'b0, 1'b1, 28'hC000010, 1'b1);
        check("full_pushpop_count", 32'(count),   32'd16);
        check("full_pushpop_ovf",   32'(ovf_cnt), 32'd2);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 28'h0, 1'b1);

        // Wrap-around stream with steady occupancy of 5.
        popped_before = n_popped;
        for (int i = 0; i < 46; i++)
            cycle(1'b0, i < 40, 28'hD000000 + 28'(i), i >= 5);
        check("wrap_popped", 32'(n_popped - popped_before), 32'd40);

        // Flush at count 7 with concurrent push and pop.
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 28'h5000000 + 28'(i), 1'b0);
        check("pre_flush_count", 32'(count), 32'd7);
        cycle(1'b1, 1'b1, 28'h5FFFFFF, 1'b1);
        check("flush_count", 32'(count),   32'd0);
        check("flush_ovf",   32'(ovf_cnt), 32'd2);

        // Overflow counter saturation.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 28'h6000000 + 28'(i), 1'b0);
        for (int i = 0; i < 260; i++) cycle(1'b0, 1'b1, 28'h7000000 + 28'(i), 1'b0);
        check("ovf_saturated", 32'(ovf_cnt), 32'd255);
        check("sat_head",      32'(route_data), 32'h6000000);

        // Asynchronous reset mid-stream, away from any clock edge.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 28'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 28'h8000000 + 28'(i), 1'b0);
        #5;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 0;
        check("arst_empty", 32'(empty),      32'd1);
        check("arst_data",  32'(route_data), 32'd0);
        check("arst_count", 32'(count),      32'd0);
        check("arst_ovf",   32'(ovf_cnt),    32'd0);
        @(negedge clk_40MHz);
        rst_n = 1'b1;
        @(posedge clk_40MHz);
        #1;
        check_state();
        cycle(1'b0, 1'b1, 28'h9ABCDEF, 1'b0);
        cycle(1'b0, 1'b0, 28'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
